imem_prog_loader: RTL and testbench
===================================

Name: imem_prog_loader

Overview:
- Sits upstream of the single-cycle core's instruction memory and loads a program image from a byte stream into it.
- Holds the core in reset while loading and releases it when the image is complete.
- Assembles little-endian 32-bit words and drives the instruction memory's word-addressed write port.
- Provides the boot path so the core runs a loaded image instead of a fixed init file.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- MEM_WORDS, 256, capacity in words; images longer than this are rejected.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high; returns the block to the header-wait state
- byte_valid  input  1  byte_data is valid this cycle
- byte_data  input  8  stream byte
- byte_ready  output  1  loader accepts a byte this cycle (transfer when byte_valid && byte_ready)
- reload  input  1  single-cycle pulse; restarts loading from DONE or ERROR
- imem_we  output  1  instruction-memory write enable
- imem_addr  output  ADDR_W  word address of the write
- imem_wdata  output  32  write data
- core_reset  output  1  reset to the core (PC, register file); high while not DONE
- load_done  output  1  image loaded, core released
- load_error  output  1  image rejected
- words_loaded  output  16  count of words written in the current load

Behaviour:
- Reset values: state HDR_LO; imem_we=0; imem_addr=0; imem_wdata=0; core_reset=1; load_done=0; load_error=0; words_loaded=0; byte_ready=0 while reset is high.
- States and transitions:
  - HDR_LO: accept a byte into cnt[7:0]; go to HDR_HI.
  - HDR_HI: accept a byte into cnt[15:8]. If cnt==0, go to DONE (CHECK when the optional feature is built in). If cnt>MEM_WORDS, go to ERROR. Otherwise go to DATA with byte index 0 and word index 0.
  - DATA: byte i (0..3) goes to word bits [8i+7:8i]. The byte with i==3 moves to WRITE.
  - WRITE: one cycle; imem_we=1, imem_addr=word index, imem_wdata=assembled word; words_loaded increments. Then go to DONE (or CHECK) if words_loaded+1==cnt, else back to DATA.
  - DONE: core_reset=0, load_done=1.
  - ERROR: core_reset=1, load_error=1.
- byte_ready is combinational from state: 1 in HDR_LO, HDR_HI, DATA and CHECK; 0 in WRITE, DONE and ERROR. No byte is ever dropped.
- Latency: the 4th byte accepted at cycle t produces imem_we=1 at cycle t+1, and the loader is ready again at t+2.
- core_reset and load_done change in the cycle the state enters DONE.
- reload in DONE or ERROR: go to HDR_LO, set core_reset=1, clear load_done, load_error and words_loaded, and zero the assembly register. reload in any other state is ignored.
- reset mid-load: abort immediately. Words already written stay in memory and are not cleared. The next load starts at word 0.
- Boundaries:
  - cnt==MEM_WORDS is accepted, with the last address MEM_WORDS-1.
  - cnt==MEM_WORDS+1 is an error, raised with no writes.
  - byte_valid gaps of any length are tolerated in every accepting state.
- imem_addr wraps never, because the bound check precedes DATA.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined: a CHECK state follows the last WRITE, or follows HDR_HI when cnt==0. It accepts one byte equal to the XOR of all data bytes; the XOR is 0 for cnt==0.
  - Match goes to DONE.
  - Mismatch goes to ERROR. Memory has already been written, but the core stays in reset.
- Undefined: the CHECK state, the XOR accumulator and their logic are absent. Completion goes directly to DONE.

Decomposition:
- Package imem_loader_pkg: state enum (HDR_LO, HDR_HI, DATA, WRITE, CHECK, DONE, ERROR), HDR_BYTES=2, BYTES_PER_WORD=4.
- Sub-module word_assembler: byte-index counter plus 32-bit shift/insert register, with an accept input, a clear input and a word_full output.
- The FSM, bound check and counters stay in imem_prog_loader.

Test Plan:
- Header 0x02,0x00, then bytes 13 05 50 00 93 05 A0 00, sent back-to-back with valid held -> writes addr0=0x00500513 and addr1=0x00A00593. imem_we is high one cycle each, byte_ready is low those cycles, and core_reset falls with load_done=1 after the 2nd write.
- Header 0x00,0x00 -> no writes, DONE the cycle after the 2nd header byte, words_loaded=0.
- Header 0x01,0x01 (257 > 256) -> ERROR, load_error=1, core_reset=1, zero writes. Then a reload pulse and a valid 1-word image -> DONE.
- Random byte_valid gaps (0–5 idle cycles) on a 256-word image -> all 256 words are correct and the last addr is 0xFF.
- reset asserted after 2 bytes of word 3 -> state HDR_LO and outputs at reset values. A fresh 1-word image then writes addr 0.
- With IMEM_LOADER_CHECKSUM_EN and the image 01 02 03 04: checksum 0x04 -> DONE; checksum 0x05 -> ERROR, core_reset held high.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and sizing for the instruction-memory program loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        HDR_LO,
        HDR_HI,
        DATA,
        WRITE,
        CHECK,
        DONE,
        ERROR
    } loader_state_t;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/word_assembler.sv
// Packs a little-endian byte stream into 32-bit words; word_full flags the
// accept that completes the current word.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        accept,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);

    localparam int IDX_W = $clog2(BYTES_PER_WORD);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    logic [IDX_W-1:0] byte_idx;

    assign word_full = accept && (byte_idx == LAST_IDX);

    // Byte i lands in bits [8i+7:8i]; the index wraps so the next word restarts at byte 0.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            byte_idx <= '0;
            word     <= '0;
        end else if (accept) begin
            word[8*byte_idx +: 8] <= byte_in;
            byte_idx <= (byte_idx == LAST_IDX) ? '0 : byte_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/imem_prog_loader.sv
// Boot loader: receives a 16-bit word count plus little-endian words and writes them
// into instruction memory, holding the core in reset until done. IMEM_LOADER_CHECKSUM_EN adds an XOR check byte.
module imem_prog_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MEM_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              load_done,
    output logic              load_error,
    output logic [15:0]       words_loaded
);

    localparam logic [16:0] MAX_WORDS = 17'(MEM_WORDS);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam loader_state_t FINISH_STATE = CHECK;
`else
    localparam loader_state_t FINISH_STATE = DONE;
`endif

    loader_state_t state, state_next;
    logic [15:0]   cnt;
    logic [15:0]   hdr_cnt;
    logic          accept;
    logic          asm_accept;
    logic          asm_clear;
    logic          word_full;
    logic [31:0]   asm_word;
    logic          check_ready;
    logic          restart;

    assign hdr_cnt    = {byte_data, cnt[7:0]};
    assign restart    = reload && (state == DONE || state == ERROR);
    assign byte_ready = !reset && (state == HDR_LO || state == HDR_HI || state == DATA || check_ready);
    assign accept     = byte_valid && byte_ready;
    assign asm_accept = accept && (state == DATA);
    assign asm_clear  = (accept && state == HDR_HI) || restart;

    word_assembler u_word_assembler (
        .clk       (clk),
        .reset     (reset),
        .accept    (asm_accept),
        .clear     (asm_clear),
        .byte_in   (byte_data),
        .word      (asm_word),
        .word_full (word_full)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] xor_acc;

    assign check_ready = (state == CHECK);

    always_ff @(posedge clk) begin
        if (reset || asm_clear) begin
            xor_acc <= '0;
        end else if (asm_accept) begin
            xor_acc <= xor_acc ^ byte_data;
        end
    end
`else
    assign check_ready = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HDR_LO;
        end else begin
            state <= state_next;
        end
    end

    // The word index of a write is simply how many words this load has already written.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            words_loaded <= '0;
        end else begin
            if (accept && state == HDR_LO) begin
                cnt[7:0] <= byte_data;
            end
            if (accept && state == HDR_HI) begin
                cnt[15:8] <= byte_data;
            end
            if (state == WRITE) begin
                words_loaded <= words_loaded + 16'd1;
            end else if (restart) begin
                words_loaded <= '0;
            end
        end
    end

    always_comb begin
        state_next = state;
        imem_we    = 1'b0;
        imem_addr  = '0;
        imem_wdata = '0;
        core_reset = 1'b1;
        load_done  = 1'b0;
        load_error = 1'b0;
        case (state)
            HDR_LO: begin
                if (accept) state_next = HDR_HI;
            end
            HDR_HI: begin
                // Bound check happens before any write, so imem_addr can never wrap.
                if (accept) begin
                    if (hdr_cnt == 16'd0) begin
                        state_next = FINISH_STATE;
                    end else if ({1'b0, hdr_cnt} > MAX_WORDS) begin
                        state_next = ERROR;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (word_full) state_next = WRITE;
            end
            WRITE: begin
                imem_we    = 1'b1;
                imem_addr  = words_loaded[ADDR_W-1:0];
                imem_wdata = asm_word;
                state_next = ((words_loaded + 16'd1) == cnt) ? FINISH_STATE : DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (accept) state_next = (byte_data == xor_acc) ? DONE : ERROR;
            end
`endif
            DONE: begin
                core_reset = 1'b0;
                load_done  = 1'b1;
                if (reload) state_next = HDR_LO;
            end
            ERROR: begin
                load_error = 1'b1;
                if (reload) state_next = HDR_LO;
            end
            default: begin
                state_next = HDR_LO;
            end
        endcase
    end

endmodule

// File: tb/tb_imem_prog_loader.sv
// Randomised self-checking bench for imem_prog_loader; a byte-stream image model
// predicts memory contents, write counts and final status.
module tb_imem_prog_loader;

    localparam int ADDR_W    = 8;
    localparam int MEM_WORDS = 256;

    logic              clk;
    logic              reset;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              reload;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_reset;
    logic              load_done;
    logic              load_error;
    logic [15:0]       words_loaded;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0]       tb_mem [MEM_WORDS];
    int                write_count;
    int                ready_during_write;
    logic [ADDR_W-1:0] last_addr;

    logic [7:0]  stream [$];
    logic [31:0] exp_mem [MEM_WORDS];
    int          model_words;
    logic [7:0]  model_xor;

    imem_prog_loader #(
        .ADDR_W    (ADDR_W),
        .MEM_WORDS (MEM_WORDS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .reload       (reload),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_reset   (core_reset),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behaves as the instruction memory, and notes any write cycle that also offers a byte.
    always @(negedge clk) begin
        if (imem_we) begin
            tb_mem[imem_addr] = imem_wdata;
            write_count++;
            last_addr = imem_addr;
            if (byte_ready) ready_during_write++;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation hung");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) begin
            n_pass++;
        end else begin
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        n_checks++;
        assert (observed === expected) begin
            n_pass++;
        end else begin
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    function automatic void start_image(input int cnt);
        stream.delete();
        model_words = 0;
        model_xor   = 8'h00;
        stream.push_back(8'(cnt));
        stream.push_back(8'(cnt >> 8));
    endfunction

    function automatic void add_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) begin
            stream.push_back(w[8*b +: 8]);
            model_xor ^= w[8*b +: 8];
        end
        exp_mem[model_words] = w;
        model_words++;
    endfunction

    function automatic void add_checksum();
`ifdef IMEM_LOADER_CHECKSUM_EN
        stream.push_back(model_xor);
`endif
    endfunction

    task automatic clear_tracking();
        write_count        = 0;
        ready_during_write = 0;
        last_addr          = '0;
    endtask

    // Called on a falling edge; returns on the falling edge after the byte transferred.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited = 0;
        byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkBit("byte_accept", byte_ready, 1'b1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic applyStimulus(input int first, input int last_excl, input int max_gap);
        for (int i = first; i < last_excl; i++) begin
            send_byte(stream[i], int'($urandom_range(0, max_gap)));
        end
    endtask

    task automatic wait_finish();
        int waited = 0;
        while (!(load_done || load_error) && waited < 32) begin
            @(negedge clk);
            waited++;
        end
        checkBit("finish_seen", load_done | load_error, 1'b1);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic checkResult(input logic exp_done, input int exp_writes);
        checkBit("load_done", load_done, exp_done);
        checkBit("load_error", load_error, !exp_done);
        checkBit("core_reset", core_reset, !exp_done);
        checkOutput("write_count", write_count, exp_writes);
        checkOutput("words_loaded", 32'(words_loaded), exp_writes);
        checkOutput("ready_in_write", ready_during_write, 0);
        for (int w = 0; w < exp_writes; w++) begin
            checkOutput($sformatf("mem[%0d]", w), tb_mem[w], exp_mem[w]);
        end
    endtask

    initial begin
        reset      = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        reload     = 1'b0;
        clear_tracking();
        repeat (3) @(negedge clk);

        $display("[TB] reset values");
        checkBit("rst_byte_ready", byte_ready, 1'b0);
        checkBit("rst_core_reset", core_reset, 1'b1);
        checkBit("rst_load_done", load_done, 1'b0);
        checkBit("rst_load_error", load_error, 1'b0);
        checkBit("rst_imem_we", imem_we, 1'b0);
        checkOutput("rst_imem_addr", 32'(imem_addr), 32'h0);
        checkOutput("rst_imem_wdata", imem_wdata, 32'h0);
        checkOutput("rst_words_loaded", 32'(words_loaded), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        checkBit("idle_byte_ready", byte_ready, 1'b1);

        $display("[TB] two-word directed image, back-to-back");
        start_image(2);
        add_word(32'h00500513);
        add_word(32'h00A00593);
        add_checksum();
        clear_tracking();
        for (int i = 0; i < stream.size(); i++) begin
            send_byte(stream[i], 0);
            if (i == 5) begin
                checkBit("lat_imem_we", imem_we, 1'b1);
                checkBit("lat_byte_ready", byte_ready, 1'b0);
                checkOutput("lat_imem_addr", 32'(imem_addr), 32'h0);
                checkOutput("lat_imem_wdata", imem_wdata, 32'h00500513);
            end
        end
        wait_finish();
        checkResult(1'b1, 2);
        checkOutput("last_addr_2w", 32'(last_addr), 32'h1);

        $display("[TB] empty image");
        pulse_reload();
        start_image(0);
        add_checksum();
        clear_tracking();
        applyStimulus(0, 2, 0);
`ifndef IMEM_LOADER_CHECKSUM_EN
        checkBit("empty_done_next_cycle", load_done, 1'b1);
`endif
        applyStimulus(2, stream.size(), 0);
        wait_finish();
        checkResult(1'b1, 0);

        $display("[TB] oversize header then reload");
        pulse_reload();
        start_image(MEM_WORDS + 1);
        clear_tracking();
        applyStimulus(0, 2, 3);
        wait_finish();
        checkResult(1'b0, 0);
        pulse_reload();
        checkBit("reload_error_cleared", load_error, 1'b0);
        checkBit("reload_core_reset", core_reset, 1'b1);
        checkBit("reload_byte_ready", byte_ready, 1'b1);
        checkOutput("reload_words_loaded", 32'(words_loaded), 32'h0);
        start_image(1);
        add_word($urandom);
        add_checksum();
        clear_tracking();
        applyStimulus(0, stream.size(), 2);
        wait_finish();
        checkResult(1'b1, 1);

        $display("[TB] full-capacity image with random gaps");
        pulse_reload();
        start_image(MEM_WORDS);
        for (int w = 0; w < MEM_WORDS; w++) add_word($urandom);
        add_checksum();
        clear_tracking();
        applyStimulus(0, stream.size(), 5);
        wait_finish();
        checkResult(1'b1, MEM_WORDS);
        checkOutput("last_addr_full", 32'(last_addr), 32'hFF);

        $display("[TB] reset in the middle of word 3");
        pulse_reload();
        start_image(5);
        for (int w = 0; w < 5; w++) add_word($urandom);
        clear_tracking();
        applyStimulus(0, 4, 2);
        pulse_reload();
        applyStimulus(4, 16, 2);
        repeat (3) @(negedge clk);
        checkOutput("abort_writes", write_count, 3);
        checkOutput("abort_words_loaded", 32'(words_loaded), 32'h3);
        reset = 1'b1;
        @(negedge clk);
        checkBit("midrst_byte_ready", byte_ready, 1'b0);
        checkBit("midrst_core_reset", core_reset, 1'b1);
        checkBit("midrst_imem_we", imem_we, 1'b0);
        checkOutput("midrst_words_loaded", 32'(words_loaded), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        checkBit("midrst_ready_after", byte_ready, 1'b1);
        start_image(1);
        add_word($urandom);
        add_checksum();
        clear_tracking();
        applyStimulus(0, stream.size(), 2);
        wait_finish();
        checkResult(1'b1, 1);
        checkOutput("fresh_last_addr", 32'(last_addr), 32'h0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        $display("[TB] checksum match and mismatch");
        pulse_reload();
        start_image(1);
        add_word(32'h04030201);
        add_checksum();
        clear_tracking();
        applyStimulus(0, stream.size(), 1);
        wait_finish();
        checkResult(1'b1, 1);
        pulse_reload();
        start_image(1);
        add_word(32'h04030201);
        stream.push_back(8'h05);
        clear_tracking();
        applyStimulus(0, stream.size(), 1);
        wait_finish();
        checkResult(1'b0, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
